// File: rtl/dig_tile_marker_if.sv
// Bus between dig_tile_marker and its surroundings: digger position, frame/level
// controls, and the dug grid exchanged with the Tunnels stage.
interface dig_tile_marker_if #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24
);
  logic              frame_clk;
  logic              level_load;
  logic [9:0]        Player_X;
  logic [9:0]        Player_Y;
  logic [GRID_H-1:0] dug_state        [GRID_W];
  logic [GRID_H-1:0] update_dug_state [GRID_W];
  logic              busy;
  logic              dig_pulse;
  logic [9:0]        tiles_dug;

  modport master (
    output frame_clk, level_load, Player_X, Player_Y, dug_state,
    input  update_dug_state, busy, dig_pulse, tiles_dug
  );

  modport slave (
    input  frame_clk, level_load, Player_X, Player_Y, dug_state,
    output update_dug_state, busy, dig_pulse, tiles_dug
  );
endinterface

// File: rtl/dig_tile_marker.sv
// Marks the tiles under the 20x20 digger sprite once per frame tick, counts
// newly dug tiles and wipes the grid column by column on level load.
//
// state   | meaning
// IDLE    | waiting for a frame edge or a pending one
// CAPTURE | latch position, range check
// DIV     | repeated subtraction: pixel -> tile col/row + remainder
// MARK0   | mark [col][row]
// MARK1   | mark [col+1][row] when sprite straddles in x
// MARK2   | mark [col][row+1] when sprite straddles in y
// MARK3   | mark [col+1][row+1] when straddling both ways
// DONE    | dig_pulse if anything new was dug
// CLEAR   | zero one column per cycle, 0..GRID_W-1
module dig_tile_marker #(
  parameter int TILE_SIZE = 20,
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  dig_tile_marker_if.slave  bus
);
  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);
  localparam logic [9:0]    TS       = 10'(TILE_SIZE);
  localparam logic [9:0]    X_LIM    = 10'(GRID_W * TILE_SIZE);
  localparam logic [9:0]    Y_LIM    = 10'(GRID_H * TILE_SIZE);
  localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_H - 1);

  typedef enum logic [3:0] {
    IDLE, CAPTURE, DIV, MARK0, MARK1, MARK2, MARK3, DONE, CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic              frame_q, pending, new_flag;
  logic [9:0]        rx, ry;
  logic [CW-1:0]     col, clr_col;
  logic [RW-1:0]     row;
  logic [9:0]        tiles_cnt;
  logic [GRID_H-1:0] grid [GRID_W];

  logic              fr_edge, abort, x_ext, y_ext;
  logic              mark_en, mark_new;
  logic [CW-1:0]     mark_x;
  logic [RW-1:0]     mark_y;

  assign fr_edge = bus.frame_clk & ~frame_q;
  assign abort   = bus.level_load & (state != CLEAR);
  assign x_ext   = (rx != 10'd0) && (col != COL_LAST);
  assign y_ext   = (ry != 10'd0) && (row != ROW_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mark_en   = 1'b0;
    mark_x    = col;
    mark_y    = row;
    case (state)
      IDLE:    if (fr_edge || pending) state_nxt = CAPTURE;
      CAPTURE: begin
        if (bus.Player_X >= X_LIM || bus.Player_Y >= Y_LIM) state_nxt = DONE;
        else                                                state_nxt = DIV;
      end
      DIV:     if (rx < TS && ry < TS) state_nxt = MARK0;
      MARK0: begin
        mark_en   = 1'b1;
        state_nxt = MARK1;
      end
      MARK1: begin
        mark_en   = x_ext;
        if (x_ext) mark_x = col + 1'b1;
        state_nxt = MARK2;
      end
      MARK2: begin
        mark_en   = y_ext;
        if (y_ext) mark_y = row + 1'b1;
        state_nxt = MARK3;
      end
      MARK3: begin
        mark_en   = x_ext & y_ext;
        if (x_ext) mark_x = col + 1'b1;
        if (y_ext) mark_y = row + 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      CLEAR:   if (clr_col == COL_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Level load wins over everything and kills any mark this cycle.
    if (abort) begin
      state_nxt = CLEAR;
      mark_en   = 1'b0;
    end
  end

  // Only tiles clear in both our copy and the Tunnels copy count as new.
  assign mark_new = mark_en & ~grid[mark_x][mark_y] & ~bus.dug_state[mark_x][mark_y];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q   <= 1'b0;
      pending   <= 1'b0;
      new_flag  <= 1'b0;
      rx        <= '0;
      ry        <= '0;
      col       <= '0;
      row       <= '0;
      clr_col   <= '0;
      tiles_cnt <= '0;
      for (int i = 0; i < GRID_W; i++) grid[i] <= '0;
    end else begin
      frame_q <= bus.frame_clk;
      if (abort) begin
        pending   <= 1'b0;
        tiles_cnt <= '0;
        clr_col   <= '0;
      end else begin
        if (state == IDLE && (fr_edge || pending)) pending <= 1'b0;
        else if (fr_edge && state != IDLE)         pending <= 1'b1;

        case (state)
          CAPTURE: begin
            rx       <= bus.Player_X;
            ry       <= bus.Player_Y;
            col      <= '0;
            row      <= '0;
            new_flag <= 1'b0;
          end
          DIV: begin
            if (rx >= TS) begin
              rx  <= rx - TS;
              col <= col + 1'b1;
            end
            if (ry >= TS) begin
              ry  <= ry - TS;
              row <= row + 1'b1;
            end
          end
          CLEAR: begin
            grid[clr_col] <= '0;
            clr_col       <= clr_col + 1'b1;
          end
          default: ;
        endcase

        if (mark_en) begin
          grid[mark_x][mark_y] <= 1'b1;
          if (mark_new) begin
            tiles_cnt <= tiles_cnt + 10'd1;
            new_flag  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.update_dug_state = grid;
  assign bus.busy             = (state != IDLE);
  assign bus.dig_pulse        = (state == DONE) & new_flag;
  assign bus.tiles_dug        = tiles_cnt;
endmodule

// File: doc/dig_tile_marker.md
Name: dig_tile_marker

Overview:
- Upstream producer of the `update_dug_state` grid consumed by the Tunnels stage.
- On each frame tick it takes the digger's pixel position and converts it to tile coordinates with a sequential divider. It then sets the dug bit of every tile the 20x20 sprite overlaps: 1, 2 or 4 tiles.
- Keeps a count of newly dug tiles for scoring.
- Clears the whole grid on level load.

Parameters:
- TILE_SIZE, 20, tile edge in pixels. Also the sprite edge.
- GRID_W, 32, tile columns (x index).
- GRID_H, 24, tile rows (y index).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame tick; one dig operation per rising edge.
- level_load  in  1  level-start request; clears the grid.
- Player_X  in  10  sprite top-left x, in pixels.
- Player_Y  in  10  sprite top-left y, in pixels.
- dug_state  in  [23:0] x 32  current grid fed back from Tunnels, indexed [x][y]. Used only for new-tile detection.
- update_dug_state  out  [23:0] x 32  registered grid to Tunnels, indexed [x][y]; 1 = dug.
- busy  out  1  high whenever state != IDLE.
- dig_pulse  out  1  one-cycle pulse in DONE if the operation dug at least one new tile.
- tiles_dug  out  10  running count of newly dug tiles (max 768, no overflow).

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - all update_dug_state bits = 0
  - tiles_dug = 0
  - busy = 0
  - dig_pulse = 0
  - state = IDLE
  - frame_clk history register = 0
  - pending = 0
- Edge detect: frame_clk is registered once. An edge is current = 1 while the registered value = 0.
- State machine: IDLE, CAPTURE, DIV, MARK0, MARK1, MARK2, MARK3, DONE, CLEAR.
  - IDLE: on edge or pending, go to CAPTURE and clear pending.
  - CAPTURE: latch rx = Player_X, ry = Player_Y; set col = 0, row = 0, new_flag = 0.
    - If Player_X >= GRID_W*TILE_SIZE (640) or Player_Y >= GRID_H*TILE_SIZE (480), go to DONE with nothing marked.
    - Otherwise go to DIV.
  - DIV: each cycle, if rx >= TILE_SIZE then rx -= TILE_SIZE and col++. Same rule for ry and row, computed in parallel.
    - When rx < TILE_SIZE and ry < TILE_SIZE at cycle start, no subtraction happens and the FSM goes to MARK0.
    - DIV length is max(col, row) + 1 cycles. Worst case is 32.
  - MARK0: mark [col][row].
  - MARK1: if rx != 0 and col+1 < GRID_W, mark [col+1][row].
  - MARK2: if ry != 0 and row+1 < GRID_H, mark [col][row+1].
  - MARK3: if both conditions hold, mark [col+1][row+1].
  - Every MARK state takes exactly one cycle, even when its condition skips the mark.
  - DONE: assert dig_pulse if new_flag is set, then go to IDLE.
- Marking a tile:
  - Set the bit in update_dug_state. Bits are only ever set outside CLEAR.
  - If the bit was 0 in both update_dug_state and dug_state, increment tiles_dug and set new_flag.
  - Statically pre-dug tiles (already 1 in dug_state) are not counted.
- Latency, from the cycle an edge is detected to returning to IDLE: 1 (CAPTURE) + DIV + 4 + 1 (DONE). Worst case 38 cycles.
- A frame edge while busy sets pending. It is one-deep: further edges are dropped. It is serviced immediately after DONE.
- CLEAR:
  - level_load = 1 in any state except CLEAR enters CLEAR on the next cycle. This aborts any dig in progress with no dig_pulse.
  - Entry clears tiles_dug and pending.
  - Column k is zeroed on CLEAR cycle k, for k = 0..31. The FSM then goes to IDLE.
  - level_load held high during CLEAR is ignored.
  - Edges arriving during CLEAR set pending.
- Priority: Reset > level_load > frame edge.
- The update_dug_state array does not track external changes to dug_state. It only ORs in this block's own marks.

Test Plan:
- Reset, then frame edge with X=0, Y=0 -> only [0][0] set; tiles_dug = 1; dig_pulse once; busy low within 7 cycles of the edge.
- X=30, Y=45 (col 1, row 2, rx=10, ry=5) -> [1][2], [2][2], [1][3], [2][3] set; tiles_dug = 4. A repeat edge at the same position -> tiles_dug stays 4 and no dig_pulse.
- X=620, Y=460 (col 31, row 23, rx=0, ry=0) -> only [31][23] set. X=625, Y=465 -> col+1 and row+1 are out of range, so only [31][23]; no new tiles counted.
- Tie dug_state[16][5] = 1 and dig at X=320, Y=100 -> [16][5] set in update_dug_state; tiles_dug unchanged; no dig_pulse.
- Frame edge at X=639, Y=479, then a second edge 3 cycles later (while busy) -> second op runs right after DONE; a third edge while busy is dropped, so exactly 2 ops.
- Pulse level_load mid-DIV after several digs -> no dig_pulse; tiles_dug = 0 next cycle; all bits 0 after 32 CLEAR cycles; X=700 then -> DONE with no marks.
